// File: rtl/rgb_led_pwm_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rgb_led_pwm_ctrl
// Description : PWM driver for four RGB LEDs (LD5..LD8, 12 active-low pins).
//               Holds a {B,G,R} duty colour per LED, loaded through a
//               single-entry valid/ready write port and committed only at
//               PWM period boundaries. An optional chase mode rotates the
//               colour-to-LED mapping every STEP_PERIODS PWM periods.
// Ports       : clk100     - system clock
//               rst        - asynchronous active-high reset
//               mode       - 0 = static mapping, 1 = chase
//               wr_valid   - colour write request
//               wr_ready   - write accepted this cycle when high
//               wr_led     - target LED index (0 = LD5 .. 3 = LD8)
//               wr_rgb     - {B,G,R} duty values, R in the LSBs
//               led_n      - active-low pins, bit 3*i+{0,1,2} = R/G/B of LED i
//               period_end - one-cycle pulse on the last clock of each period
// Revision    : 1.0 - initial release
// ============================================================================
module rgb_led_pwm_ctrl #(
  parameter int PWM_BITS     = 8,
  parameter int PRESC        = 4,
  parameter int STEP_PERIODS = 49020
) (
  input  logic                  clk100,
  input  logic                  rst,
  input  logic                  mode,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [1:0]            wr_led,
  input  logic [3*PWM_BITS-1:0] wr_rgb,
  output logic [11:0]           led_n,
  output logic                  period_end
);

  localparam int c_PRESC_W = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int c_STEP_W  = ($clog2(STEP_PERIODS) > 16) ? $clog2(STEP_PERIODS) : 16;

  localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(PRESC - 1);
  // Counter stops one short of all-ones so a full-scale duty means 100 % on.
  localparam logic [PWM_BITS-1:0]  c_PWM_LAST   = {{(PWM_BITS-1){1'b1}}, 1'b0};
  localparam logic [c_STEP_W-1:0]  c_STEP_LAST  = c_STEP_W'(STEP_PERIODS - 1);

  logic [c_PRESC_W-1:0]  r_presc;
  logic [PWM_BITS-1:0]   r_pwm_cnt;
  logic [c_STEP_W-1:0]   r_step;
  logic [1:0]            r_offset;
  logic                  r_pend;
  logic [1:0]            r_pend_led;
  logic [3*PWM_BITS-1:0] r_pend_rgb;
  logic [3*PWM_BITS-1:0] r_colour [4];

  logic                  w_tick;
  logic                  w_period_last;
  logic                  w_accept;
  logic [11:0]           w_on;

  assign w_tick        = (r_presc == c_PRESC_LAST);
  assign w_period_last = w_tick && (r_pwm_cnt == c_PWM_LAST);
  assign wr_ready      = !r_pend;
  assign w_accept      = wr_valid && !r_pend;

  // Timebase: prescaler, PWM counter and the registered period pulse.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      r_presc    <= '0;
      r_pwm_cnt  <= '0;
      period_end <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + c_PRESC_W'(1);
      if (w_tick)
        r_pwm_cnt <= (r_pwm_cnt == c_PWM_LAST) ? '0 : r_pwm_cnt + PWM_BITS'(1);
      period_end <= w_period_last;
    end
  end

  // Write buffer. The commit edge is the same edge on which the PWM counter
  // wraps to 0, so the new colour is in place for the whole next period.
  // Accept and commit are exclusive because accept needs an empty buffer.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      r_pend     <= 1'b0;
      r_pend_led <= '0;
      r_pend_rgb <= '0;
      for (int k = 0; k < 4; k++) r_colour[k] <= '0;
    end else if (w_accept) begin
      r_pend     <= 1'b1;
      r_pend_led <= wr_led;
      r_pend_rgb <= wr_rgb;
    end else if (r_pend && w_period_last) begin
      r_colour[r_pend_led] <= r_pend_rgb;
      r_pend               <= 1'b0;
    end
  end

  // Chase stepping. Leaving chase mode clears the step count but keeps the
  // current offset so the display freezes where it is.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      r_step   <= '0;
      r_offset <= '0;
    end else if (!mode) begin
      r_step <= '0;
    end else if (w_period_last) begin
      if (r_step == c_STEP_LAST) begin
        r_step   <= '0;
        r_offset <= r_offset + 2'd1;
      end else begin
        r_step <= r_step + c_STEP_W'(1);
      end
    end
  end

  // LED i shows colour (i + offset) mod 4; the 2-bit add wraps naturally.
  for (genvar i = 0; i < 4; i++) begin : g_led
    logic [1:0] w_src;
    assign w_src = 2'(i) + r_offset;
    for (genvar c = 0; c < 3; c++) begin : g_ch
      assign w_on[3*i+c] = r_pwm_cnt < r_colour[w_src][c*PWM_BITS +: PWM_BITS];
    end
  end

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) led_n <= 12'hFFF;
    else     led_n <= ~w_on;
  end

endmodule
`default_nettype wire

// File: tb/tb_rgb_led_pwm_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_rgb_led_pwm_ctrl
// Description : Directed self-checking bench for rgb_led_pwm_ctrl with
//               PRESC=1, PWM_BITS=8 (255-cycle period), STEP_PERIODS=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rgb_led_pwm_ctrl;

  localparam int PERIOD = 255;

  logic        clk100 = 1'b0;
  logic        rst;
  logic        mode;
  logic        wr_valid;
  logic        wr_ready;
  logic [1:0]  wr_led;
  logic [23:0] wr_rgb;
  logic [11:0] led_n;
  logic        period_end;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          lowcnt [12];
  logic [11:0] full_mask;
  logic [11:0] any_mask;
  int          waited;
  int          waited2;

  rgb_led_pwm_ctrl #(
    .PWM_BITS     (8),
    .PRESC        (1),
    .STEP_PERIODS (2)
  ) dut (
    .clk100     (clk100),
    .rst        (rst),
    .mode       (mode),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_led     (wr_led),
    .wr_rgb     (wr_rgb),
    .led_n      (led_n),
    .period_end (period_end)
  );

  always #5 clk100 = ~clk100;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next negedge at which period_end is high.
  task automatic sync_pe();
    int n = 0;
    do begin
      @(negedge clk100);
      n++;
    end while (!period_end && n < 2000);
    if (!period_end) chk("period_end_timeout", {31'd0, period_end}, 32'd1);
  endtask

  // Called at a period_end sample; counts low samples per pin over the
  // following displayed period and ends on the next period_end sample.
  task automatic measure();
    for (int b = 0; b < 12; b++) lowcnt[b] = 0;
    repeat (PERIOD) begin
      @(negedge clk100);
      for (int b = 0; b < 12; b++) if (!led_n[b]) lowcnt[b]++;
    end
    full_mask = '0;
    any_mask  = '0;
    for (int b = 0; b < 12; b++) begin
      if (lowcnt[b] == PERIOD) full_mask[b] = 1'b1;
      if (lowcnt[b] > 0)       any_mask[b]  = 1'b1;
    end
  endtask

  // Present a write at the current negedge and hold it until accepted.
  task automatic do_write(input logic [1:0] l, input logic [23:0] c, output int w);
    w        = 0;
    wr_led   = l;
    wr_rgb   = c;
    wr_valid = 1'b1;
    while (!wr_ready && w < 2000) begin
      @(negedge clk100);
      w++;
    end
    if (!wr_ready) chk("wr_ready_timeout", {31'd0, wr_ready}, 32'd1);
    @(negedge clk100);
    wr_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mode = 1'b0; wr_valid = 1'b0; wr_led = '0; wr_rgb = '0;
    repeat (3) @(negedge clk100);
    chk("reset_led_n",      {20'd0, led_n}, 32'h0000_0FFF);
    chk("reset_wr_ready",   {31'd0, wr_ready}, 32'd1);
    chk("reset_period_end", {31'd0, period_end}, 32'd0);
    rst = 1'b0;

    // Light LED0 fully, then reset mid-period with a pending write.
    sync_pe();
    do_write(2'd0, 24'hFFFFFF, waited);
    sync_pe();
    measure();
    chk("led0_white", {20'd0, full_mask}, 32'h0000_0007);
    do_write(2'd1, 24'hFFFFFF, waited);
    repeat (100) @(negedge clk100);
    #2 rst = 1'b1;
    #1;
    chk("midrst_led_n",    {20'd0, led_n}, 32'h0000_0FFF);
    chk("midrst_wr_ready", {31'd0, wr_ready}, 32'd1);
    @(negedge clk100);
    rst = 1'b0;
    sync_pe();
    for (int p = 0; p < 3; p++) begin
      measure();
      chk("post_reset_dark", {20'd0, any_mask}, 32'd0);
    end

    // Static write to LED1: R=128, G=255, B=0.
    do_write(2'd1, 24'h00FF80, waited);
    sync_pe();
    measure();
    chk("static_r_count", lowcnt[3], 32'd128);
    chk("static_g_count", lowcnt[4], 32'd255);
    chk("static_b_count", lowcnt[5], 32'd0);
    chk("static_others",  {20'd0, any_mask & ~12'h018}, 32'd0);

    // Back-to-back writes to LED2: R=10 then R=20.
    sync_pe();
    fork
      begin
        do_write(2'd2, 24'h00000A, waited);
        do_write(2'd2, 24'h000014, waited2);
      end
      begin
        measure();
        chk("bp_period1_r", lowcnt[6], 32'd0);
        measure();
        chk("bp_period2_r", lowcnt[6], 32'd10);
        measure();
        chk("bp_period3_r", lowcnt[6], 32'd20);
      end
    join
    chk("bp_first_wait",  waited,  32'd0);
    chk("bp_second_wait", waited2, 32'd254);

    // Write accepted on the cycle before the commit cycle.
    sync_pe();
    fork
      begin
        repeat (253) @(negedge clk100);
        do_write(2'd3, 24'h0000C8, waited);
      end
      begin
        measure();
        chk("cb_old_duty", lowcnt[9], 32'd0);
        measure();
        chk("cb_new_duty", lowcnt[9], 32'd200);
      end
    join
    chk("cb_wait", waited, 32'd0);

    // Chase: clean state, red on colour 0.
    @(negedge clk100);
    rst = 1'b1;
    @(negedge clk100);
    rst = 1'b0;
    sync_pe();
    do_write(2'd0, 24'h0000FF, waited);
    sync_pe();
    mode = 1'b1;
    for (int p = 0; p < 11; p++) begin
      int off;
      int exp_led;
      off     = (p / 2) % 4;
      exp_led = (4 - off) % 4;
      measure();
      chk($sformatf("chase_full_p%0d", p), {20'd0, full_mask}, 32'd1 << (3 * exp_led));
      chk($sformatf("chase_any_p%0d", p),  {20'd0, any_mask},  32'd1 << (3 * exp_led));
    end
    // Offset is 1 here and a step is due at the end of the next period.
    mode = 1'b0;
    for (int p = 0; p < 3; p++) begin
      measure();
      chk("frozen_pos", {20'd0, any_mask}, 32'h0000_0200);
    end

    // Commit to LED2 (green) on the same period_end as an offset step.
    mode = 1'b1;
    measure();
    chk("sim_pre_x", {20'd0, any_mask}, 32'h0000_0200);
    fork
      do_write(2'd2, 24'h00FF00, waited);
      begin
        measure();
        chk("sim_pre_y", {20'd0, any_mask}, 32'h0000_0200);
      end
    join
    chk("sim_wait", waited, 32'd0);
    measure();
    chk("sim_after_full", {20'd0, full_mask}, 32'h0000_0042);
    chk("sim_after_any",  {20'd0, any_mask},  32'h0000_0042);
    mode = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
